pwm_ramp_sequencer: RTL and testbench



---
 rtl/pwm_ramp_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_pwm_ramp_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_sequencer.sv
// pwm_ramp_sequencer
// ------------------
// Slew-rate-limited duty-cycle sequencer. Keeps a target and a committed
// (current) duty per channel and, on each ramp tick, walks every channel's
// current duty toward its target by at most step_i. Each changed value is
// issued as a single-cycle load on the PWM core's value/load interface.
// The PWM channels are write-only, so current[] here is the authoritative copy.
//
// Ports:
//   clk_i        block clock
//   rst_i        synchronous active-high reset
//   tgt_wr_i     target write strobe (tgt_chan_i, tgt_value_i)
//   tgt_chan_i   target channel; indices >= C_NUM_PWM are ignored
//   tgt_value_i  new target value
//   step_i       maximum per-tick change (unsigned)
//   tick_i       starts a ramp pass when idle; sets overrun_o when busy
//   reload_i     forces the next pass to load every channel
//   ovr_clr_i    clears overrun_o
//   pwm_load_o   one-cycle load strobe to the PWM core
//   pwm_chan_o   channel index of the load
//   pwm_value_o  value of the load
//   busy_o       pass in progress
//   settled_o    all channels at target at the end of the last pass
//   overrun_o    sticky: a tick arrived while busy
module pwm_ramp_sequencer #(
   parameter int C_NUM_PWM   = 8,
   parameter int C_PWM_WIDTH = 24
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   tgt_wr_i,
   input  logic [5:0]             tgt_chan_i,
   input  logic [C_PWM_WIDTH-1:0] tgt_value_i,
   input  logic [C_PWM_WIDTH-1:0] step_i,
   input  logic                   tick_i,
   input  logic                   reload_i,
   input  logic                   ovr_clr_i,
   output logic                   pwm_load_o,
   output logic [5:0]             pwm_chan_o,
   output logic [C_PWM_WIDTH-1:0] pwm_value_o,
   output logic                   busy_o,
   output logic                   settled_o,
   output logic                   overrun_o
);

   localparam int IDX_W = (C_NUM_PWM > 1) ? $clog2(C_NUM_PWM) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_NUM_PWM - 1);

   typedef enum logic {
      S_IDLE,
      S_SCAN
   } state_t;

   state_t                   state_q, state_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic                     force_q, force_d;
   logic                     reload_pend_q, reload_pend_d;
   logic                     settled_acc_q, settled_acc_d;
   logic                     settled_q, settled_d;
   logic                     overrun_q, overrun_d;
   logic                     load_q, load_d;
   logic [5:0]               chan_q, chan_d;
   logic [C_PWM_WIDTH-1:0]   value_q, value_d;

   logic [C_PWM_WIDTH-1:0]   target_w  [C_NUM_PWM];
   logic [C_PWM_WIDTH-1:0]   current_w [C_NUM_PWM];

   // Evaluation datapath for the channel under scan.
   logic [C_PWM_WIDTH-1:0]   cur_sel;
   logic [C_PWM_WIDTH-1:0]   tgt_sel;
   logic [C_PWM_WIDTH-1:0]   diff;
   logic [C_PWM_WIDTH-1:0]   move;
   logic [C_PWM_WIDTH-1:0]   new_val;
   logic                     scanning;
   logic                     do_load;

   assign scanning = (state_q == S_SCAN);
   assign cur_sel  = current_w[idx_q];
   assign tgt_sel  = target_w[idx_q];

   // The move is clamped to the remaining distance, so the result lands
   // between current and target and can neither overshoot nor wrap.
   always_comb begin
      diff    = '0;
      move    = '0;
      new_val = cur_sel;
      if (tgt_sel >= cur_sel) begin
         diff    = tgt_sel - cur_sel;
         move    = (step_i < diff) ? step_i : diff;
         new_val = cur_sel + move;
      end else begin
         diff    = cur_sel - tgt_sel;
         move    = (step_i < diff) ? step_i : diff;
         new_val = cur_sel - move;
      end
   end

   assign do_load = scanning && ((new_val != cur_sel) || force_q);

   // Per-channel storage. Target writes land at the end of the cycle, so an
   // evaluation of the same channel in that cycle still sees the old target.
   for (genvar gi = 0; gi < C_NUM_PWM; gi++) begin : g_chan
      logic [C_PWM_WIDTH-1:0] target_q;
      logic [C_PWM_WIDTH-1:0] current_q;
      logic                   wr_hit;
      logic                   upd_hit;

      assign wr_hit  = tgt_wr_i && (tgt_chan_i == 6'(gi));
      assign upd_hit = do_load && (idx_q == IDX_W'(gi));

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            target_q  <= '0;
            current_q <= '0;
         end else begin
            if (wr_hit) begin
               target_q <= tgt_value_i;
            end
            if (upd_hit) begin
               current_q <= new_val;
            end
         end
      end

      assign target_w[gi]  = target_q;
      assign current_w[gi] = current_q;
   end

   always_comb begin
      logic acc_next;
      state_d       = state_q;
      idx_d         = idx_q;
      force_d       = force_q;
      reload_pend_d = reload_pend_q;
      settled_acc_d = settled_acc_q;
      settled_d     = settled_q;
      load_d        = 1'b0;
      chan_d        = chan_q;
      value_d       = value_q;
      overrun_d     = overrun_q;
      acc_next      = settled_acc_q & (new_val == tgt_sel);

      // Set has priority over clear when both arrive during a pass.
      if (tick_i && scanning) begin
         overrun_d = 1'b1;
      end else if (ovr_clr_i) begin
         overrun_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (tick_i) begin
               state_d       = S_SCAN;
               idx_d         = '0;
               force_d       = reload_pend_q;
               // A reload coinciding with the accepted tick applies to the
               // pass after this one.
               reload_pend_d = reload_i;
               settled_acc_d = 1'b1;
            end else if (reload_i) begin
               reload_pend_d = 1'b1;
            end
         end
         S_SCAN: begin
            if (reload_i) begin
               reload_pend_d = 1'b1;
            end
            if (do_load) begin
               load_d  = 1'b1;
               chan_d  = 6'(idx_q);
               value_d = new_val;
            end
            settled_acc_d = acc_next;
            if (idx_q == LAST_IDX) begin
               state_d   = S_IDLE;
               idx_d     = '0;
               settled_d = acc_next;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= S_IDLE;
         idx_q         <= '0;
         force_q       <= 1'b0;
         reload_pend_q <= 1'b1;
         settled_acc_q <= 1'b1;
         settled_q     <= 1'b1;
         overrun_q     <= 1'b0;
         load_q        <= 1'b0;
         chan_q        <= '0;
         value_q       <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         force_q       <= force_d;
         reload_pend_q <= reload_pend_d;
         settled_acc_q <= settled_acc_d;
         settled_q     <= settled_d;
         overrun_q     <= overrun_d;
         load_q        <= load_d;
         chan_q        <= chan_d;
         value_q       <= value_d;
      end
   end

   assign pwm_load_o  = load_q;
   assign pwm_chan_o  = chan_q;
   assign pwm_value_o = value_q;
   assign busy_o      = scanning;
   assign settled_o   = settled_q;
   assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Testbench for pwm_ramp_sequencer: directed scenarios followed by random
// traffic, all outputs compared every cycle against a pass-level model that
// tracks targets, committed duties and pending flags with plain arithmetic.
module tb_pwm_ramp_sequencer;
   localparam int N = 8;
   localparam int W = 24;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          tgt_wr_i = 1'b0;
   logic [5:0]    tgt_chan_i = '0;
   logic [W-1:0]  tgt_value_i = '0;
   logic [W-1:0]  step_i = '0;
   logic          tick_i = 1'b0;
   logic          reload_i = 1'b0;
   logic          ovr_clr_i = 1'b0;
   logic          pwm_load_o;
   logic [5:0]    pwm_chan_o;
   logic [W-1:0]  pwm_value_o;
   logic          busy_o;
   logic          settled_o;
   logic          overrun_o;

   pwm_ramp_sequencer #(.C_NUM_PWM(N), .C_PWM_WIDTH(W)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .tgt_wr_i    (tgt_wr_i),
      .tgt_chan_i  (tgt_chan_i),
      .tgt_value_i (tgt_value_i),
      .step_i      (step_i),
      .tick_i      (tick_i),
      .reload_i    (reload_i),
      .ovr_clr_i   (ovr_clr_i),
      .pwm_load_o  (pwm_load_o),
      .pwm_chan_o  (pwm_chan_o),
      .pwm_value_o (pwm_value_o),
      .busy_o      (busy_o),
      .settled_o   (settled_o),
      .overrun_o   (overrun_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state.
   longint tgt_m [N];
   longint cur_m [N];
   bit     in_pass_m = 0;
   int     pass_pos_m = 0;
   bit     force_m = 0;
   bit     pend_m = 1;
   bit     acc_m = 1;
   bit     settled_m = 1;
   bit     ovr_m = 0;
   bit     eload = 0;
   longint echan = 0;
   longint evalue = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance the model across the coming clock edge using the driven inputs.
   task automatic model_step();
      longint step, delta, nv;
      int     k;
      if (rst_i) begin
         for (int i = 0; i < N; i++) begin
            tgt_m[i] = 0;
            cur_m[i] = 0;
         end
         pend_m = 1; in_pass_m = 0; pass_pos_m = 0; force_m = 0;
         eload = 0; echan = 0; evalue = 0;
         settled_m = 1; acc_m = 1; ovr_m = 0;
         return;
      end
      step  = longint'(step_i);
      eload = 0;
      if (tick_i && in_pass_m) ovr_m = 1;
      else if (ovr_clr_i) ovr_m = 0;
      if (in_pass_m) begin
         k     = pass_pos_m;
         delta = tgt_m[k] - cur_m[k];
         if (delta > step) delta = step;
         if (delta < -step) delta = -step;
         nv = cur_m[k] + delta;
         if (nv != cur_m[k] || force_m) begin
            eload = 1; echan = k; evalue = nv; cur_m[k] = nv;
         end
         acc_m = acc_m && (nv == tgt_m[k]);
         if (reload_i) pend_m = 1;
         if (k == N - 1) begin
            in_pass_m = 0;
            settled_m = acc_m;
         end else begin
            pass_pos_m = k + 1;
         end
      end else if (tick_i) begin
         in_pass_m = 1; pass_pos_m = 0; force_m = pend_m; pend_m = reload_i; acc_m = 1;
      end else if (reload_i) begin
         pend_m = 1;
      end
      if (tgt_wr_i && tgt_chan_i < N) tgt_m[tgt_chan_i] = longint'(tgt_value_i);
   endtask

   // One clock: model the edge, then compare all outputs on the falling edge
   // and return strobes to idle.
   task automatic clk_cycle();
      model_step();
      @(negedge clk_i);
      check_val("load",    32'(pwm_load_o),  32'(eload));
      check_val("chan",    32'(pwm_chan_o),  32'(echan));
      check_val("value",   32'(pwm_value_o), 32'(evalue));
      check_val("busy",    32'(busy_o),      32'(in_pass_m));
      check_val("settled", 32'(settled_o),   32'(settled_m));
      check_val("overrun", 32'(overrun_o),   32'(ovr_m));
      if (pwm_load_o === 1'b1)
         $display("load ch=%0d value=%0d t=%0t", pwm_chan_o, pwm_value_o, $time);
      rst_i = 0; tgt_wr_i = 0; tick_i = 0; reload_i = 0; ovr_clr_i = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) clk_cycle();
   endtask

   task automatic write_tgt(input int ch, input int val);
      tgt_wr_i = 1; tgt_chan_i = 6'(ch); tgt_value_i = W'(val);
      clk_cycle();
   endtask

   task automatic do_tick(input int after);
      tick_i = 1;
      clk_cycle();
      idle(after);
   endtask

   initial begin
      // Reset and initial forced pass of zeros, then a quiet pass.
      rst_i = 1; clk_cycle();
      rst_i = 1; clk_cycle();
      idle(3);
      do_tick(N + 3);
      do_tick(N + 3);

      // Ramp channel 3 toward 1000 in steps of 300.
      step_i = W'(300);
      write_tgt(3, 1000);
      for (int i = 0; i < 4; i++) do_tick(N + 2);

      // Full-scale step down on channel 5: one load, no wrap.
      step_i = {W{1'b1}};
      write_tgt(5, 1000);
      do_tick(N + 2);
      write_tgt(5, 0);
      do_tick(N + 2);

      // Overrun handling with a slow ramp so passes keep loading.
      step_i = W'(1);
      for (int c = 0; c < N; c++) write_tgt(c, 50);
      do_tick(2);
      do_tick(N + 3);              // tick at T+3 -> overrun
      ovr_clr_i = 1; clk_cycle();
      do_tick(3);
      tick_i = 1; ovr_clr_i = 1; clk_cycle();
      idle(N);
      ovr_clr_i = 1; clk_cycle();
      do_tick(N - 1);
      do_tick(N + 2);              // tick at T+N -> overrun
      ovr_clr_i = 1; clk_cycle();
      do_tick(N);
      do_tick(N + 2);              // tick at T+N+1 -> accepted

      // Target write colliding with channel 2 evaluation; ignored channel 9.
      step_i = W'(1000);
      write_tgt(2, 100);
      do_tick(N + 2);
      do_tick(2);
      write_tgt(2, 700);           // cycle T+3: channel 2 evaluated now
      idle(N);
      write_tgt(9, 1234);
      do_tick(N + 2);

      // Reset in the middle of a pass, then the forced reload of zeros.
      reload_i = 1; clk_cycle();
      do_tick(3);
      rst_i = 1; clk_cycle();
      idle(2);
      do_tick(N + 2);

      // Random traffic.
      step_i = W'(200);
      for (int i = 0; i < 3000; i++) begin
         rst_i       = ($urandom % 400) == 0;
         tgt_wr_i    = ($urandom % 3) == 0;
         tgt_chan_i  = 6'($urandom_range(0, 11));
         tgt_value_i = (($urandom % 8) == 0) ? W'($urandom) : W'($urandom_range(0, 2000));
         tick_i      = ($urandom % 7) == 0;
         reload_i    = ($urandom % 25) == 0;
         ovr_clr_i   = ($urandom % 12) == 0;
         if (!in_pass_m && !tick_i && ($urandom % 40) == 0) begin
            case ($urandom % 4)
               0:       step_i = '0;
               1:       step_i = {W{1'b1}};
               default: step_i = W'($urandom_range(1, 500));
            endcase
         end
         clk_cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
